// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first.
// Result and final borrow are registered and held until the next completion.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             br;

    logic a0;
    logic b0;
    logic d1;
    logic bw1;
    logic d;
    logic bw2;
    logic br_next;
    logic last;

    // Two cascaded half-subtractor cells; the cell borrows are ORed.
    assign a0      = a_sr[0];
    assign b0      = b_sr[0];
    assign d1      = a0 ^ b0;
    assign bw1     = ~a0 & b0;
    assign d       = d1 ^ br;
    assign bw2     = ~d1 & br;
    assign br_next = bw1 | bw2;
    assign last    = (cnt == CW'(WIDTH - 1));

    always_comb begin
        res_next            = res_sr >> 1;
        res_next[WIDTH-1]   = d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            Diff   <= '0;
            Borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= A;
                        b_sr <= B;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    br     <= br_next;
                    cnt    <= cnt + CW'(1);
                    // Last bit: publish the completed result as DONE is entered.
                    if (last) begin
                        Diff   <= res_next;
                        Borrow <= br_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and random checks for serial_subtractor_ctrl at WIDTH=8 and WIDTH=1.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_serial_subtractor_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       busy;
    logic       done;
    logic [7:0] Diff;
    logic       Borrow;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       borrow1;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int last_done_cyc = -1;
    logic [7:0] held_diff = '0;
    logic       held_borrow = 1'b0;

    serial_subtractor_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .Diff(Diff), .Borrow(Borrow)
    );

    serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .Diff(diff1), .Borrow(borrow1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ed;
        logic       eb;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Runs one operation from IDLE; checks latency, busy, result hold and result.
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic eb,
                       input string name);
        int n;
        int nbusy;
        logic held_ok;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = ~a; B = ~b;
        n = 0; nbusy = 0; held_ok = 1'b1;
        while (!done && n < 40) begin
            if (busy) nbusy++;
            if (Diff !== held_diff || Borrow !== held_borrow) held_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({name, " latency"}, n, 8);
        chk({name, " busy_cycles"}, nbusy, 8);
        chk({name, " hold"}, held_ok, 1);
        chk({name, " busy_in_done"}, busy, 0);
        chk({name, " result"}, {Borrow, Diff}, {eb, ed});
        if (last_done_cyc >= 0)
            chk({name, " spacing_ok"}, (cyc - last_done_cyc) >= 10, 1);
        last_done_cyc = cyc;
        held_diff = ed;
        held_borrow = eb;
        @(negedge clk);
        chk({name, " done_pulse"}, done, 0);
    endtask

    task automatic op1(input logic a, input logic b, input logic ed,
                       input logic eb);
        @(negedge clk);
        a1 = a; b1 = b; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("w1 busy", {busy1, done1}, 2'b10);
        @(negedge clk);
        chk("w1 done", {busy1, done1}, 2'b01);
        chk("w1 result", {borrow1, diff1}, {eb, ed});
        @(negedge clk);
        chk("w1 idle", {busy1, done1}, 2'b00);
    endtask

    initial begin
        vec_t vecs[8];
        int nd;
        vecs[0] = '{8'h5A, 8'h33, 8'h27, 1'b0};
        vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1};
        vecs[2] = '{8'hFF, 8'h01, 8'hFE, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'h09, 8'h03, 8'h06, 1'b0};
        vecs[5] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[7] = '{8'h80, 8'h7F, 8'h01, 1'b0};

        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("reset outputs", {busy, done, Borrow, Diff}, 0);
        chk("reset w1", {busy1, done1, borrow1, diff1}, 0);

        for (int i = 0; i < 8; i++) op8(vecs[i].a, vecs[i].b,
                                        vecs[i].ed, vecs[i].eb, "vec");

        // Start re-pulsed during SHIFT and DONE must be ignored.
        @(negedge clk);
        A = 8'h5A; B = 8'h33; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        A = 8'h00; B = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        while (!done && nd < 40) begin
            @(negedge clk);
            nd++;
        end
        chk("ign result", {Borrow, Diff}, {1'b0, 8'h27});
        chk("ign latency", nd, 5);
        A = 8'h09; B = 8'h03; start = 1'b1;
        @(negedge clk);
        chk("ign start_in_done", {busy, done}, 2'b00);
        @(negedge clk);
        start = 1'b0;
        chk("ign accept_idle", busy, 1);
        nd = 0;
        while (!done && nd < 40) begin
            @(negedge clk);
            nd++;
        end
        chk("ign second", {Borrow, Diff}, {1'b0, 8'h06});
        held_diff = 8'h06;
        held_borrow = 1'b0;
        last_done_cyc = -1;
        @(negedge clk);

        // Reset in the middle of SHIFT aborts and clears results.
        op8(8'h5A, 8'h33, 8'h27, 1'b0, "pre_rst");
        @(negedge clk);
        A = 8'h5A; B = 8'h33; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid outputs", {busy, done, Borrow, Diff}, 0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) nd++;
            @(negedge clk);
        end
        chk("rst_mid no_done", nd, 0);
        held_diff = '0;
        held_borrow = 1'b0;
        last_done_cyc = -1;
        op8(8'h09, 8'h03, 8'h06, 1'b0, "post_rst");

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic [8:0] ref9;
            ra = 8'($urandom);
            rb = 8'($urandom);
            ref9 = {1'b0, ra} - {1'b0, rb};
            op8(ra, rb, ref9[7:0], ref9[8], "rand");
        end

        op1(1'b0, 1'b0, 1'b0, 1'b0);
        op1(1'b1, 1'b0, 1'b1, 1'b0);
        op1(1'b0, 1'b1, 1'b1, 1'b1);
        op1(1'b1, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_ctrl.md
SERIAL_SUBTRACTOR_CTRL -- requirements
Module: serial_subtractor_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand and result width in bits (legal range 1..32).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-006 Port A, input, WIDTH bits: minuend (unsigned); sampled on the edge start is accepted.
REQ-007 Port B, input, WIDTH bits: subtrahend (unsigned); sampled on the edge start is accepted.
REQ-008 Port busy, output, 1 bit: high while the subtraction is in progress (SHIFT state).
REQ-009 Port done, output, 1 bit: one-cycle pulse when Diff and Borrow become valid.
REQ-010 Port Diff, output, WIDTH bits: registered result (A - B) mod 2^WIDTH.
REQ-011 Port Borrow, output, 1 bit: registered final borrow; 1 iff A < B.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 SHALL, on that edge, load A and B into internal shift registers, clear the borrow flop, clear the bit counter, and move to SHIFT.
REQ-014 IDLE with start=0 SHALL stay in IDLE.
REQ-015 Each SHIFT cycle SHALL process one bit, LSB first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-016 The per-bit datapath SHALL be two cascaded half-subtractor cells: diff = a ^ b, borrow = ~a & b, with the two cell borrows ORed.
REQ-017 Each SHIFT cycle SHALL shift both operand registers right by one and shift d into the MSB of an internal result shift register.
REQ-018 SHIFT SHALL last exactly WIDTH cycles; on the edge that processes bit WIDTH-1, the FSM SHALL move to DONE.
REQ-019 On entering DONE, Diff SHALL be loaded from the result register and Borrow from the final br_next.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-021 Latency: start accepted at edge k; done=1 in the cycle after edge k+WIDTH; next start is accepted no earlier than edge k+WIDTH+2.
REQ-022 busy SHALL be 1 exactly in SHIFT; done SHALL be 1 exactly in DONE; the two are never high together.
REQ-023 start in SHIFT or DONE SHALL be ignored, with no effect on operands or results.
REQ-024 Diff and Borrow SHALL hold their last values from the DONE load until the next DONE, including through IDLE and SHIFT.
REQ-025 A and B changes after the accepting edge SHALL NOT affect the operation in progress.
REQ-026 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide. With WIDTH=1, SHIFT SHALL last one cycle.

Reset
REQ-027 rst=1 SHALL, on the next rising edge, force state to IDLE and set busy=0, done=0, Diff=0, Borrow=0, clear the counter, borrow flop and shift registers.
REQ-028 rst SHALL take priority over start and over any state transition.
REQ-029 rst asserted mid-operation SHALL abort the operation, with no done pulse and Diff/Borrow cleared to 0.
REQ-030 rst SHALL have no asynchronous effect.

Verification
REQ-031 Basic subtraction, WIDTH=8: A=0x5A, B=0x33, start pulse -> busy for 8 cycles, then done pulse with Diff=0x27, Borrow=0.
REQ-032 Underflow: A=0x10, B=0x20 -> Diff=0xF0, Borrow=1; A=0xFF, B=0x01 -> Diff=0xFE, Borrow=0; A=0x00, B=0x00 -> Diff=0x00, Borrow=0.
REQ-033 Ignored start and operand stability: start re-pulsed at cycle 3 of SHIFT with A=0x00, B=0xFF -> result still 0x27/0 from the first operands; done pulses once; the next start is accepted only in IDLE.
REQ-034 Reset mid-operation: rst high at SHIFT cycle 4 -> next cycle busy=0, done=0, Diff=0, Borrow=0, state IDLE; a following start with 0x09-0x03 -> Diff=0x06 after 8 cycles.
REQ-035 WIDTH=1 build: exhaust all four A,B pairs -> (0,0)=0/0, (1,0)=1/0, (0,1)=1/1, (1,1)=0/0; done at start edge+2.
REQ-036 Random: 1000 random A,B pairs at WIDTH=8 compared against the reference {Borrow,Diff} = {1'b0,A} - {1'b0,B}, with the done-to-done spacing checked at >= WIDTH+2 cycles.
